// File: rtl/uart_pkg.sv
// Shared types and helpers for the devboard host-link UART.
// Optional feature macro: UART_PARITY_EN adds a parity state to both FSMs.
package uart_pkg;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
`ifdef UART_PARITY_EN
    TxParity,
`endif
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
`ifdef UART_PARITY_EN
    RxParity,
`endif
    RxStop,
    RxBreak,
    RxRearm
  } rx_state_e;

  // Two-of-three vote over the mid-bit samples.
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through single-clock FIFO with occupancy count.
// A pop while full makes room for a push in the same cycle; pops while empty are ignored.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_12m,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Occupancy next-state from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_12m) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array, left unreset so it can map onto distributed RAM.
  always_ff @(posedge clk_12m) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_fifo_if.sv
// Single-clock UART for the host link: integer baud divider, valid/ready TX,
// majority-vote RX into a FWFT FIFO, sticky frame/overflow/break/parity status.
// Optional feature macro: UART_PARITY_EN (adds PARITY_ODD and a parity bit after data).
module uart_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned BAUD_DIV   = 104,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
`ifdef UART_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic                        clk_12m,
  input  logic                        rst,
  output logic                        tx,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic                        rx,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  input  logic                        err_clr,
  output logic                        rx_frame_err,
  output logic                        rx_overflow,
  output logic                        rx_break,
  output logic                        rx_parity_err
);

  localparam int unsigned CntW    = $clog2(BAUD_DIV);
  localparam int unsigned Mid     = BAUD_DIV / 2;
  localparam logic [CntW-1:0] CntMax  = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] SampLo  = CntW'(Mid - 1);
  localparam logic [CntW-1:0] SampMid = CntW'(Mid);
  localparam logic [CntW-1:0] SampHi  = CntW'(Mid + 1);
  localparam logic [3:0]      DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);

  // ---------------------------------------------------------------- TX
  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;
  logic                 tx_end;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  assign tx_end   = (tx_cnt_q == CntMax);
  assign tx_ready = (tx_state_q == TxIdle);
  assign tx       = tx_q;

  // TX sequencing; the line level is derived from the next state so tx is registered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tx_state_q != TxIdle) tx_cnt_d = tx_end ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      TxIdle: begin
        if (tx_valid) begin
          tx_state_d = TxStart;
          tx_shift_d = tx_data;
          tx_cnt_d   = '0;
`ifdef UART_PARITY_EN
          tx_par_d   = (^tx_data) ^ PARITY_ODD;
`endif
        end
      end
      TxStart: begin
        if (tx_end) begin
          tx_state_d = TxData;
          tx_bit_d   = '0;
        end
      end
      TxData: begin
        if (tx_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == DataLast) begin
`ifdef UART_PARITY_EN
            tx_state_d = TxParity;
`else
            tx_state_d = TxStop;
`endif
            tx_bit_d   = '0;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      TxParity: begin
        if (tx_end) begin
          tx_state_d = TxStop;
          tx_bit_d   = '0;
        end
      end
`endif
      TxStop: begin
        if (tx_end) begin
          if (tx_bit_q == StopLast) tx_state_d = TxIdle;
          else                      tx_bit_d   = tx_bit_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    case (tx_state_d)
      TxStart:  tx_d = 1'b0;
      TxData:   tx_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
      TxParity: tx_d = tx_par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // TX state registers.
  always_ff @(posedge clk_12m) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [2:0]           rx_samp_q, rx_samp_d;
  logic                 rx_end, rx_vote;
  logic                 rx_push, frame_set, break_set;
  logic                 frame_q, overflow_q, break_q;
  logic                 fifo_full, fifo_empty, ovf_set;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad_q, rx_par_bad_d, par_set, parity_q;
`endif

  assign rx_end  = (rx_cnt_q == CntMax);
  assign rx_vote = majority3(rx_samp_q);

  // RX framing: bit timing restarts each boundary, value decided at the last count.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_samp_d  = rx_samp_q;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    break_set  = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_bad_d = rx_par_bad_q;
    par_set      = 1'b0;
`endif
    if (rx_state_q != RxIdle && rx_state_q != RxRearm) begin
      rx_cnt_d = rx_end ? '0 : rx_cnt_q + 1'b1;
      if (rx_cnt_q == SampLo || rx_cnt_q == SampMid || rx_cnt_q == SampHi) begin
        rx_samp_d = {rx_samp_q[1:0], rx_sync_q};
      end
    end
    case (rx_state_q)
      RxIdle: begin
        // Count 1 here so the synchronised falling edge sits at count 0.
        if (!rx_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = CntW'(1);
        end
      end
      RxStart: begin
        if (rx_end) begin
          rx_state_d = rx_vote ? RxIdle : RxData;
          rx_bit_d   = '0;
        end
      end
      RxData: begin
        if (rx_end) begin
          rx_shift_d = {rx_vote, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DataLast) begin
`ifdef UART_PARITY_EN
            rx_state_d = RxParity;
`else
            rx_state_d = RxStop;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RxParity: begin
        if (rx_end) begin
          rx_par_bad_d = rx_vote ^ (^rx_shift_q) ^ PARITY_ODD;
          rx_state_d   = RxStop;
        end
      end
`endif
      RxStop: begin
        if (rx_end) begin
          if (rx_vote) begin
            rx_push    = 1'b1;
`ifdef UART_PARITY_EN
            par_set    = rx_par_bad_q;
`endif
            rx_state_d = RxRearm;
          end else if (rx_shift_q == '0) begin
            break_set  = 1'b1;
            rx_state_d = RxBreak;
          end else begin
            frame_set  = 1'b1;
            rx_state_d = RxRearm;
          end
        end
      end
      RxBreak: begin
        if (rx_end && rx_vote) rx_state_d = RxRearm;
      end
      RxRearm: begin
        if (rx_sync_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Synchroniser and RX state registers.
  always_ff @(posedge clk_12m) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_samp_q  <= '0;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_samp_q  <= rx_samp_d;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= rx_par_bad_d;
`endif
    end
  end

  // A push lost to a full FIFO is only an overflow if no pop frees a slot this cycle.
  assign ovf_set = rx_push & fifo_full & ~(rx_ready & ~fifo_empty);

  // Sticky status: a set event wins over err_clr.
  always_ff @(posedge clk_12m) begin
    if (rst) begin
      frame_q    <= 1'b0;
      overflow_q <= 1'b0;
      break_q    <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      frame_q    <= frame_set | (frame_q & ~err_clr);
      overflow_q <= ovf_set | (overflow_q & ~err_clr);
      break_q    <= break_set | (break_q & ~err_clr);
`ifdef UART_PARITY_EN
      parity_q   <= par_set | (parity_q & ~err_clr);
`endif
    end
  end

  assign rx_frame_err = frame_q;
  assign rx_overflow  = overflow_q;
  assign rx_break     = break_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = parity_q;
`else
  assign rx_parity_err = 1'b0;
`endif
  assign rx_valid = ~fifo_empty;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_12m   (clk_12m),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_shift_q),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .count     (rx_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_fifo_if.sv
// Directed + randomized bench for uart_fifo_if (BAUD_DIV=8, DATA_BITS=8, FIFO_DEPTH=4).
// Expected frames and received bytes come from a queue-based model of the serial format.
module tb_uart_fifo_if;

  localparam int unsigned DB = 8;
  localparam int unsigned BD = 8;
  localparam int unsigned SB = 1;
  localparam int unsigned FD = 4;

  typedef logic bitq_t [$];

  logic         clk_12m = 1'b0;
  logic         rst = 1'b1;
  logic         tx;
  logic [DB-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         rx_line;
  logic [DB-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready = 1'b0;
  logic [2:0]   rx_count;
  logic         err_clr = 1'b0;
  logic         rx_frame_err, rx_overflow, rx_break, rx_parity_err;

  logic         loop_en = 1'b0;
  logic         rx_drv = 1'b1;
`ifdef UART_PARITY_EN
  logic         par_flip = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  assign rx_line = loop_en ? tx : rx_drv;

  always #5 clk_12m = ~clk_12m;

  uart_fifo_if #(
    .DATA_BITS  (DB),
    .BAUD_DIV   (BD),
    .STOP_BITS  (SB),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk_12m       (clk_12m),
    .rst           (rst),
    .tx            (tx),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx            (rx_line),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_count      (rx_count),
    .err_clr       (err_clr),
    .rx_frame_err  (rx_frame_err),
    .rx_overflow   (rx_overflow),
    .rx_break      (rx_break),
    .rx_parity_err (rx_parity_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_12m);
    #1;
  endtask

  // Serial frame as the line should carry it: start, data LSB first, [parity], stop(s).
  function automatic bitq_t build_frame(input logic [7:0] d, input logic stop_val);
    bitq_t f;
    f.push_back(1'b0);
    for (int i = 0; i < DB; i++) f.push_back(d[i]);
`ifdef UART_PARITY_EN
    f.push_back((^d) ^ par_flip);
`endif
    for (int i = 0; i < SB; i++) f.push_back((i == 0) ? stop_val : 1'b1);
    return f;
  endfunction

  task automatic send_rx(input logic [7:0] d, input logic stop_val);
    bitq_t f;
    f = build_frame(d, stop_val);
    foreach (f[i]) begin
      rx_drv = f[i];
      repeat (BD) tick();
    end
    rx_drv = 1'b1;
    repeat (2) tick();
  endtask

  task automatic send_tx(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      tick();
      n++;
    end
    check("tx_ready_wait", {31'b0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_count(input int n, input string tag);
    int k = 0;
    while (int'(rx_count) != n && k < 3000) begin
      tick();
      k++;
    end
    check(tag, {29'b0, rx_count}, n);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_valid"}, {31'b0, rx_valid}, 32'd1);
    check(tag, {24'b0, rx_data}, {24'b0, e});
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, {28'b0, rx_parity_err, rx_break, rx_overflow, rx_frame_err}, {28'b0, exp});
  endtask

  initial begin
    bitq_t f;
    int low_cycles;
    logic [7:0] d;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("reset_rx_count", {29'b0, rx_count}, 32'd0);
    check_flags("reset_flags", 4'b0000);

    // TX 0xA5 waveform, one bit per BAUD_DIV cycles
    f = build_frame(8'hA5, 1'b1);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid   = 1'b0;
    low_cycles = 0;
    foreach (f[i]) begin
      for (int k = 0; k < BD; k++) begin
        check($sformatf("tx_a5_bit%0d", i), {31'b0, tx}, {31'b0, f[i]});
        if (!tx_ready) low_cycles++;
        tick();
      end
    end
    check("tx_ready_low_cycles", low_cycles, f.size() * BD);
    check("tx_ready_after_frame", {31'b0, tx_ready}, 32'd1);
    check("tx_idle_after_frame", {31'b0, tx}, 32'd1);

    // Loopback of directed bytes back to back
    loop_en = 1'b1;
    send_tx(8'h00); exp_q.push_back(8'h00);
    send_tx(8'hFF); exp_q.push_back(8'hFF);
    send_tx(8'h3C); exp_q.push_back(8'h3C);
    wait_count(3, "loop_count3");
    pop_check("loop_pop0");
    pop_check("loop_pop1");
    pop_check("loop_pop2");
    check("loop_empty", {31'b0, rx_valid}, 32'd0);
    check_flags("loop_flags", 4'b0000);

    // Randomized loopback
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      repeat ($urandom_range(0, 5)) tick();
      send_tx(d);
      wait_count(1, "rand_count");
      pop_check("rand_pop");
    end

    // Reset during a TX frame (also discards the partial loopback RX frame)
    send_tx(8'h5A);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("midrst_tx", {31'b0, tx}, 32'd1);
    check("midrst_tx_ready", {31'b0, tx_ready}, 32'd1);
    rst = 1'b0;
    repeat (12 * BD) tick();
    check("midrst_rx_count", {29'b0, rx_count}, 32'd0);
    check_flags("midrst_flags", 4'b0000);
    loop_en = 1'b0;

    // False start: 3-cycle low glitch
    rx_drv = 1'b0;
    repeat (3) tick();
    rx_drv = 1'b1;
    repeat (5 * BD) tick();
    check("false_start_count", {29'b0, rx_count}, 32'd0);
    check_flags("false_start_flags", 4'b0000);

    // Overflow: five frames into a four-entry FIFO without popping
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      if (i < FD) exp_q.push_back(d);
      send_rx(d, 1'b1);
    end
    repeat (6) tick();
    check("ovf_count", {29'b0, rx_count}, FD);
    check_flags("ovf_flags", 4'b0010);
    for (int i = 0; i < FD; i++) pop_check("ovf_pop");
    clear_flags();
    check_flags("ovf_cleared", 4'b0000);

    // Frame error: nonzero data with stop bit 0
    send_rx(8'h55, 1'b0);
    repeat (6) tick();
    check("ferr_count", {29'b0, rx_count}, 32'd0);
    check_flags("ferr_flags", 4'b0001);
    clear_flags();
    check_flags("ferr_cleared", 4'b0000);

    // Break: line low for 30 bit times, then recover with 0x41
    rx_drv = 1'b0;
    repeat (30 * BD) tick();
    check("brk_count", {29'b0, rx_count}, 32'd0);
    check_flags("brk_flags", 4'b0100);
    rx_drv = 1'b1;
    repeat (3 * BD) tick();
    exp_q.push_back(8'h41);
    send_rx(8'h41, 1'b1);
    repeat (6) tick();
    check("brk_rx_count", {29'b0, rx_count}, 32'd1);
    pop_check("brk_pop41");
    check("brk_sticky", {31'b0, rx_break}, 32'd1);
    clear_flags();
    check_flags("brk_cleared", 4'b0000);

`ifdef UART_PARITY_EN
    // Wrong parity bit: byte still delivered, parity flag set
    par_flip = 1'b1;
    exp_q.push_back(8'h01);
    send_rx(8'h01, 1'b1);
    par_flip = 1'b0;
    repeat (6) tick();
    check_flags("par_flags", 4'b1000);
    pop_check("par_pop01");
    clear_flags();
    check_flags("par_cleared", 4'b0000);
`else
    check("parity_tied_low", {31'b0, rx_parity_err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
